// File: rtl/ucsbece154b_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Read hits are served combinationally; read misses refill a whole line and stores always go to memory.
module ucsbece154b_dcache #(
  parameter int NUM_SETS    = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM_i,
  input  logic        MemWriteM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  output logic [31:0] ReadDataM_o,
  output logic        StallM_o,
  output logic        MemReadReq_o,
  output logic        MemWriteReq_o,
  output logic [31:0] MemAddr_o,
  output logic [31:0] MemWriteData_o,
  input  logic        MemReady_i,
  input  logic        MemDataValid_i,
  input  logic [31:0] MemReadData_i
);

  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = 32 - OB - IB - 2;
  localparam logic [OB-1:0] LAST = OB'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RREQ, FILL, WRITE} state_t;

  state_t state, state_next;

  logic [NUM_SETS-1:0] valid;
  logic [TB-1:0]       tags  [NUM_SETS];
  logic [31:0]         words [NUM_SETS][BLOCK_WORDS];
  logic [OB-1:0]       cnt;

  logic [OB-1:0] offset;
  logic [IB-1:0] index;
  logic [TB-1:0] tag;
  logic          hit;
  logic          unused_bits;

  assign offset      = ALUResultM_i[OB+1:2];
  assign index       = ALUResultM_i[OB+IB+1:OB+2];
  assign tag         = ALUResultM_i[31:OB+IB+2];
  assign hit         = valid[index] && (tags[index] == tag);
  assign unused_bits = ^ALUResultM_i[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The line is invalidated as the fill starts so a half-written line can never hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        RREQ: begin
          if (MemReady_i) begin
            valid[index] <= 1'b0;
            cnt          <= '0;
          end
        end
        FILL: begin
          if (MemDataValid_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) valid[index] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && MemDataValid_i) begin
      words[index][cnt] <= MemReadData_i;
      if (cnt == LAST) tags[index] <= tag;
    end
    if (state == WRITE && MemReady_i && hit) words[index][offset] <= WriteDataM_i;
  end

  always_comb begin
    state_next     = state;
    StallM_o       = 1'b0;
    MemReadReq_o   = 1'b0;
    MemWriteReq_o  = 1'b0;
    MemAddr_o      = '0;
    MemWriteData_o = '0;
    ReadDataM_o    = '0;
    case (state)
      IDLE: begin
        if (MemWriteM_i) begin
          StallM_o   = 1'b1;
          state_next = WRITE;
        end else if (MemReadM_i) begin
          if (hit) begin
            ReadDataM_o = words[index][offset];
          end else begin
            StallM_o   = 1'b1;
            state_next = RREQ;
          end
        end
      end
      RREQ: begin
        MemReadReq_o = 1'b1;
        MemAddr_o    = {ALUResultM_i[31:OB+2], {(OB+2){1'b0}}};
        StallM_o     = 1'b1;
        if (MemReady_i) state_next = FILL;
      end
      FILL: begin
        StallM_o = 1'b1;
        if (MemDataValid_i && cnt == LAST) state_next = IDLE;
      end
      WRITE: begin
        MemWriteReq_o  = 1'b1;
        MemAddr_o      = {ALUResultM_i[31:2], 2'b00};
        MemWriteData_o = WriteDataM_i;
        StallM_o       = ~MemReady_i;
        if (MemReady_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs read as zero for as long as reset is held, even mid-transaction.
    if (!reset) begin
      StallM_o       = 1'b0;
      MemReadReq_o   = 1'b0;
      MemWriteReq_o  = 1'b0;
      MemAddr_o      = '0;
      MemWriteData_o = '0;
      ReadDataM_o    = '0;
    end
  end

endmodule
